uart_buffered: RTL
==================

Name: uart_buffered

Overview:
Full-duplex UART with compile-time frame format, baud divisor and FIFO depth. It has a transmit FIFO and a receive FIFO so the host can queue and drain several characters without per-byte handshaking. It also flags parity, framing and overrun errors. It is the drop-in serial endpoint for the command/telemetry path, replacing the fixed 8N1 single-byte UART.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
BAUD_DIV, 5208, clk cycles per bit period; minimum 8.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
FIFO_DEPTH, 8, entries per FIFO; power of 2, minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
RX  in  1  serial input, asynchronous
TX  out  1  serial output, idle high
tx_data  in  DATA_BITS  character to queue
tx_wr  in  1  push tx_data into the TX FIFO
tx_full  out  1  TX FIFO holds FIFO_DEPTH entries
tx_count  out  $clog2(FIFO_DEPTH+1)  TX FIFO occupancy
tx_busy  out  1  serializer is mid-frame or the TX FIFO is non-empty
rx_data  out  DATA_BITS  head of the RX FIFO (first-word fall-through)
rx_valid  out  1  RX FIFO non-empty
rx_rd  in  1  pop the RX FIFO head
rx_count  out  $clog2(FIFO_DEPTH+1)  RX FIFO occupancy
parity_err  out  1  sticky: a frame was received with bad parity
frame_err  out  1  sticky: a frame was received with stop bit = 0
rx_overrun  out  1  sticky: a good frame arrived while the RX FIFO was full
clr_err  in  1  clear all three sticky error flags

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Values after rst: TX=1, tx_full=0, tx_count=0, tx_busy=0, rx_valid=0, rx_count=0, all error flags 0, rx_data=0.
- Reset mid-frame aborts the frame immediately, empties both FIFOs and drops TX high on the same edge.
- Frame format: start(0), data LSB first, parity bit if PARITY!=0 (even: XOR of data; odd: its inverse), one stop(1). Every bit lasts BAUD_DIV clks.
- FIFO push rule (both FIFOs): a push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the push is dropped and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- A pop when the FIFO is empty is ignored.
- TX FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty; the head is popped into the shift register on that edge.
  - With tx_wr sampled at edge k into an empty FIFO and an idle engine, TX goes low at edge k+2.
  - STOP -> START directly if the FIFO is non-empty, so back-to-back frames have no idle gap. Otherwise STOP -> IDLE.
  - TX is driven from a register (glitch-free).
- RX input path: RX passes through a 2-flop synchronizer reset to 1.
- RX FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronized falling edge.
  - The start bit is re-sampled at BAUD_DIV/2 clks. If it is high, the start is treated as a glitch and the FSM returns to IDLE.
  - Each following bit is sampled every BAUD_DIV clks thereafter, at bit centre.
  - At the stop sample: stop=0 sets frame_err; a parity mismatch sets parity_err; in either case the character is discarded.
  - If both checks pass, the character is pushed. If the push is refused, rx_overrun is set and the new character is dropped; FIFO contents are kept.
  - After the stop sample the FSM returns to IDLE immediately, so it can resync on the next start edge within half a bit.
- RX latency: rx_valid/rx_count update on the edge after the stop-bit sample.
- rx_data is combinational from FIFO memory at the read pointer. It is valid whenever rx_valid=1.
- Error flags: set wins over clr_err in the same cycle. Flags never clear without clr_err or rst.
- tx_rd/rx push in the same cycle as a host pop: both take effect, and the count changes by the net amount.

Test Plan:
1. BAUD_DIV=16, PARITY=1, write 0xA5 -> TX low 2 clks after tx_wr; bits 0,1,0,1,0,0,1,0,1,P=0,1 at 16 clks each; TX high after 176 clks; tx_busy=0 afterwards.
2. TX looped to RX; write 0x00, 0xFF, 0x3C back-to-back -> contiguous 528-clk burst; rx_data reads 0x00, 0xFF, 0x3C in order; no error flags set.
3. Write 9 characters in consecutive cycles with the engine stalled by reset release timing -> tx_full=1 at count 8; the 9th is dropped; exactly 8 frames are sent.
4. Drive 9 good frames into RX without rx_rd -> rx_count=8, rx_overrun=1; the first 8 characters read back intact; clr_err clears the flag.
5. Frames with stop=0, then with wrong parity -> frame_err=1, then parity_err=1; rx_count unchanged at 0. Assert clr_err in the same cycle as a new error -> the flag stays 1.
6. RX low pulse of 4 clks -> no frame received. Assert rst at bit 5 of a TX frame -> TX=1 on the next edge; tx_count=rx_count=0; the next write transmits correctly.

Source files
------------

// File: rtl/uart_buffered.sv
// Full-duplex UART with transmit and receive FIFOs, compile-time frame format and baud divisor.
// The receiver flags parity, framing and overrun errors in sticky flags that clr_err clears.
module uart_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 5208,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             RX,
    output logic                             TX,
    input  logic [DATA_BITS-1:0]             tx_data,
    input  logic                             tx_wr,
    output logic                             tx_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  tx_count,
    output logic                             tx_busy,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    input  logic                             rx_rd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_count,
    output logic                             parity_err,
    output logic                             frame_err,
    output logic                             rx_overrun,
    input  logic                             clr_err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 2);
    localparam bit            HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // ---------------- transmit FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wptr_reg, tx_rptr_reg;
    logic [CW-1:0]        tx_count_reg;
    logic                 tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    state_t               tx_state_reg;
    logic [BW-1:0]        tx_baud_reg;
    logic [IW-1:0]        tx_bit_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_par_reg;
    logic                 tx_line_reg;
    logic                 tx_bit_end;

    assign tx_head    = tx_mem[tx_rptr_reg];
    assign tx_bit_end = (tx_baud_reg == BIT_LAST);
    assign tx_pop     = (tx_count_reg != '0) &&
                        ((tx_state_reg == ST_IDLE) || (tx_state_reg == ST_STOP && tx_bit_end));
    assign tx_push    = tx_wr && ((tx_count_reg != DEPTH_C) || tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wptr_reg] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_reg  <= '0;
            tx_rptr_reg  <= '0;
            tx_count_reg <= '0;
        end else begin
            if (tx_push)
                tx_wptr_reg <= tx_wptr_reg + 1'b1;
            if (tx_pop)
                tx_rptr_reg <= tx_rptr_reg + 1'b1;
            if (tx_push && !tx_pop)
                tx_count_reg <= tx_count_reg + CW'(1);
            else if (!tx_push && tx_pop)
                tx_count_reg <= tx_count_reg - CW'(1);
        end
    end

    // ---------------- transmit serializer ----------------
    // The line register follows the state one cycle late, so every bit keeps its full width.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= ST_IDLE;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_line_reg  <= 1'b1;
        end else begin
            case (tx_state_reg)
                ST_START:  tx_line_reg <= 1'b0;
                ST_DATA:   tx_line_reg <= tx_shift_reg[0];
                ST_PARITY: tx_line_reg <= tx_par_reg;
                default:   tx_line_reg <= 1'b1;
            endcase

            if (tx_pop) begin
                tx_shift_reg <= tx_head;
                tx_par_reg   <= (^tx_head) ^ PAR_ODD;
                tx_state_reg <= ST_START;
                tx_baud_reg  <= '0;
            end else if (tx_state_reg != ST_IDLE) begin
                if (!tx_bit_end) begin
                    tx_baud_reg <= tx_baud_reg + BW'(1);
                end else begin
                    tx_baud_reg <= '0;
                    case (tx_state_reg)
                        ST_START: begin
                            tx_state_reg <= ST_DATA;
                            tx_bit_reg   <= '0;
                        end
                        ST_DATA: begin
                            tx_shift_reg <= tx_shift_reg >> 1;
                            if (tx_bit_reg == DATA_LAST)
                                tx_state_reg <= HAS_PAR ? ST_PARITY : ST_STOP;
                            else
                                tx_bit_reg <= tx_bit_reg + IW'(1);
                        end
                        ST_PARITY: tx_state_reg <= ST_STOP;
                        default:   tx_state_reg <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign TX       = tx_line_reg;
    assign tx_full  = (tx_count_reg == DEPTH_C);
    assign tx_count = tx_count_reg;
    assign tx_busy  = (tx_state_reg != ST_IDLE) || (tx_count_reg != '0);

    // ---------------- receive deserializer ----------------
    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    state_t               rx_state_reg;
    logic [BW-1:0]        rx_baud_reg;
    logic [IW-1:0]        rx_bit_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic                 rx_pbit_reg;
    logic                 rx_bit_end, rx_stop_sample, rx_par_ok;
    logic                 rx_good, rx_par_bad, rx_frame_bad;

    assign rx_bit_end     = (rx_baud_reg == BIT_LAST);
    assign rx_stop_sample = (rx_state_reg == ST_STOP) && rx_bit_end;
    assign rx_par_ok      = !HAS_PAR || (rx_pbit_reg == ((^rx_shift_reg) ^ PAR_ODD));
    assign rx_frame_bad   = rx_stop_sample && !rx_sync_reg;
    assign rx_par_bad     = rx_stop_sample && !rx_par_ok;
    assign rx_good        = rx_stop_sample && rx_sync_reg && rx_par_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= ST_IDLE;
            rx_baud_reg  <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_pbit_reg  <= 1'b0;
        end else begin
            rx_meta_reg <= RX;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            case (rx_state_reg)
                ST_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= ST_START;
                        rx_baud_reg  <= '0;
                    end
                end
                ST_START: begin
                    // Half-bit re-check rejects glitches and centres later samples.
                    if (rx_baud_reg == HALF_LAST) begin
                        rx_baud_reg  <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync_reg ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_bit_end) begin
                        rx_baud_reg  <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                        if (rx_bit_reg == DATA_LAST)
                            rx_state_reg <= HAS_PAR ? ST_PARITY : ST_STOP;
                        else
                            rx_bit_reg <= rx_bit_reg + IW'(1);
                    end else begin
                        rx_baud_reg <= rx_baud_reg + BW'(1);
                    end
                end
                ST_PARITY: begin
                    if (rx_bit_end) begin
                        rx_baud_reg  <= '0;
                        rx_pbit_reg  <= rx_sync_reg;
                        rx_state_reg <= ST_STOP;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + BW'(1);
                    end
                end
                default: begin
                    if (rx_bit_end) begin
                        rx_baud_reg  <= '0;
                        rx_state_reg <= ST_IDLE;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + BW'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- receive FIFO and error flags ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wptr_reg, rx_rptr_reg;
    logic [CW-1:0]        rx_count_reg;
    logic                 rx_push, rx_pop;
    logic                 parity_err_reg, frame_err_reg, rx_overrun_reg;

    assign rx_pop  = rx_rd && (rx_count_reg != '0);
    assign rx_push = rx_good && ((rx_count_reg != DEPTH_C) || rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wptr_reg] <= rx_shift_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_reg    <= '0;
            rx_rptr_reg    <= '0;
            rx_count_reg   <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            if (rx_push)
                rx_wptr_reg <= rx_wptr_reg + 1'b1;
            if (rx_pop)
                rx_rptr_reg <= rx_rptr_reg + 1'b1;
            if (rx_push && !rx_pop)
                rx_count_reg <= rx_count_reg + CW'(1);
            else if (!rx_push && rx_pop)
                rx_count_reg <= rx_count_reg - CW'(1);

            if (rx_par_bad)
                parity_err_reg <= 1'b1;
            else if (clr_err)
                parity_err_reg <= 1'b0;
            if (rx_frame_bad)
                frame_err_reg <= 1'b1;
            else if (clr_err)
                frame_err_reg <= 1'b0;
            if (rx_good && !rx_push)
                rx_overrun_reg <= 1'b1;
            else if (clr_err)
                rx_overrun_reg <= 1'b0;
        end
    end

    assign rx_data    = (rx_count_reg != '0) ? rx_mem[rx_rptr_reg] : '0;
    assign rx_valid   = (rx_count_reg != '0);
    assign rx_count   = rx_count_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign rx_overrun = rx_overrun_reg;
endmodule
